// File: rtl/cache_pkg.sv
// Shared types, widths and address-field helpers for the 2-way read-only cache.
package cache_pkg;

  localparam int CACHE_SETS       = 128;
  localparam int CACHE_LINE_WORDS = 4;
  localparam int CACHE_ADDR_W     = 32;
  localparam int CACHE_DATA_W     = 32;

  // Field widths of a byte address: | tag | index | word | byte(2) |
  localparam int WORD_W   = $clog2(CACHE_LINE_WORDS);
  localparam int OFFSET_W = WORD_W + 2;
  localparam int INDEX_W  = $clog2(CACHE_SETS);
  localparam int TAG_W    = CACHE_ADDR_W - OFFSET_W - INDEX_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_MISS_REQ = 3'd2,
    ST_REFILL   = 3'd3,
    ST_RESP     = 3'd4
  } cache_state_e;

  function automatic logic [INDEX_W-1:0] get_index(input logic [CACHE_ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [CACHE_ADDR_W-1:0] addr);
    return addr[CACHE_ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [WORD_W-1:0] get_word(input logic [CACHE_ADDR_W-1:0] addr);
    return addr[2 +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag, valid and data storage for both ways. Combinational read of one set,
// single-word beat write, tag write (which also marks the line valid),
// per-line invalidate and a whole-array flush.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int SETS       = CACHE_SETS,
  parameter int LINE_WORDS = CACHE_LINE_WORDS,
  parameter int DATA_W     = CACHE_DATA_W
) (
  input  logic                   gclk,
  input  logic                   grst_n,
  input  logic                   flush,
  input  logic [INDEX_W-1:0]     rd_set,
  input  logic [WORD_W-1:0]      rd_word,
  output logic [1:0][TAG_W-1:0]  rd_tag,
  output logic [1:0]             rd_valid,
  output logic [1:0][DATA_W-1:0] rd_data,
  input  logic                   wr_en,
  input  logic                   wr_way,
  input  logic [INDEX_W-1:0]     wr_set,
  input  logic [WORD_W-1:0]      wr_word,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   inval,
  input  logic                   tag_we,
  input  logic [TAG_W-1:0]       wr_tag
);

  logic [1:0][SETS-1:0] valid_q;

  for (genvar w = 0; w < 2; w++) begin : g_way
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [DATA_W-1:0] data_mem [SETS*LINE_WORDS];

    assign rd_tag[w]   = tag_mem[rd_set];
    assign rd_valid[w] = valid_q[w][rd_set];
    assign rd_data[w]  = data_mem[{rd_set, rd_word}];

    // Tag and data contents need no reset; valid bits guard them.
    always_ff @(posedge gclk) begin
      if (wr_en && (wr_way == 1'(w))) data_mem[{wr_set, wr_word}] <= wr_data;
      if (tag_we && (wr_way == 1'(w))) tag_mem[wr_set] <= wr_tag;
    end
  end

  // Valid bits: flush wins, otherwise invalidate on first beat / set on tag write.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      if (inval)  valid_q[wr_way][wr_set] <= 1'b0;
      if (tag_we) valid_q[wr_way][wr_set] <= 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl_2way.sv
// Read-only 2-way set-associative cache controller: lookup, miss request,
// line refill from the memory bus and the replacement-policy event interface.
module cache_ctrl_2way
  import cache_pkg::*;
#(
  parameter int SETS       = CACHE_SETS,
  parameter int LINE_WORDS = CACHE_LINE_WORDS,
  parameter int ADDR_W     = CACHE_ADDR_W,
  parameter int DATA_W     = CACHE_DATA_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [ADDR_W-1:0]  req_addr_i,
  output logic               resp_valid_o,
  output logic [DATA_W-1:0]  resp_data_o,
  input  logic               flush_i,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [ADDR_W-1:0]  mem_req_addr_o,
  input  logic               mem_rvalid_i,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  output logic [INDEX_W-1:0] rp_set_index_o,
  output logic               rp_way0_valid_o,
  output logic               rp_way1_valid_o,
  output logic               rp_hit_o,
  output logic               rp_miss_o,
  output logic               rp_fill_o,
  output logic               rp_way_hit_o,
  output logic               rp_way_filled_o,
  input  logic               rp_victim_i
);

  cache_state_e              state_q, state_d;
  logic [ADDR_W-1:0]         addr_q;
  logic                      victim_q;
  logic [WORD_W-1:0]         beat_q;
  logic                      resp_hit_q;
  logic [DATA_W-1:0]         resp_data_q;
  logic                      live_q;

  logic [INDEX_W-1:0]        set;
  logic [TAG_W-1:0]          tag;
  logic [WORD_W-1:0]         word;
  logic [1:0][TAG_W-1:0]     rd_tag;
  logic [1:0]                rd_valid;
  logic [1:0][DATA_W-1:0]    rd_data;
  logic                      hit0, hit1, hit;
  logic                      in_lookup, in_refill, in_resp, track;
  logic                      beat, last_beat, accept;

  assign set  = get_index(addr_q);
  assign tag  = get_tag(addr_q);
  assign word = get_word(addr_q);

  assign in_lookup = (state_q == ST_LOOKUP);
  assign in_refill = (state_q == ST_REFILL);
  assign in_resp   = (state_q == ST_RESP);
  assign track     = in_lookup | in_refill | in_resp;

  // Way 0 wins if both ever matched; fills never duplicate a tag.
  assign hit0 = rd_valid[0] && (rd_tag[0] == tag);
  assign hit1 = rd_valid[1] && (rd_tag[1] == tag);
  assign hit  = hit0 | hit1;

  assign beat      = in_refill & mem_rvalid_i;
  assign last_beat = beat & (beat_q == WORD_W'(LINE_WORDS - 1));

  // live_q keeps req_ready_o low while reset is held.
  assign req_ready_o = live_q && (state_q == ST_IDLE) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;

  assign resp_valid_o = resp_hit_q | in_resp;
  assign resp_data_o  = resp_hit_q ? resp_data_q : (in_resp ? rd_data[victim_q] : '0);

  assign mem_req_valid_o = (state_q == ST_MISS_REQ);
  assign mem_req_addr_o  = mem_req_valid_o ? {tag, set, {OFFSET_W{1'b0}}} : '0;

  assign rp_set_index_o  = track ? set : '0;
  assign rp_way0_valid_o = track & rd_valid[0];
  assign rp_way1_valid_o = track & rd_valid[1];
  assign rp_hit_o        = in_lookup & hit;
  assign rp_way_hit_o    = in_lookup & hit & ~hit0;
  assign rp_miss_o       = in_lookup & ~hit;
  assign rp_fill_o       = last_beat;
  assign rp_way_filled_o = last_beat & victim_q;

  cache_line_store #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .DATA_W     (DATA_W)
  ) u_store (
    .gclk     (clk_i),
    .grst_n   (rst_ni),
    .flush    (flush_i && (state_q == ST_IDLE)),
    .rd_set   (set),
    .rd_word  (word),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_en    (beat),
    .wr_way   (victim_q),
    .wr_set   (set),
    .wr_word  (beat_q),
    .wr_data  (mem_rdata_i),
    .inval    (beat && (beat_q == '0)),
    .tag_we   (last_beat),
    .wr_tag   (tag)
  );

  // Next-state logic for the lookup/refill sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept)          state_d = ST_LOOKUP;
      ST_LOOKUP:   state_d = hit ? ST_IDLE : ST_MISS_REQ;
      ST_MISS_REQ: if (mem_req_ready_i) state_d = ST_REFILL;
      ST_REFILL:   if (last_beat)       state_d = ST_RESP;
      ST_RESP:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State, latched request, victim, beat counter and the registered hit response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      victim_q    <= 1'b0;
      beat_q      <= '0;
      resp_hit_q  <= 1'b0;
      resp_data_q <= '0;
      live_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= 1'b1;
      resp_hit_q <= rp_hit_o;
      if (accept)    addr_q   <= req_addr_i;
      if (rp_miss_o) victim_q <= rp_victim_i;
      if (state_q == ST_MISS_REQ) beat_q <= '0;
      else if (beat)              beat_q <= beat_q + 1'b1;
      if (rp_hit_o) resp_data_q <= hit0 ? rd_data[0] : rd_data[1];
    end
  end

endmodule

// File: doc/cache_ctrl_2way.md
Name: cache_ctrl_2way

Overview:
Read-only, two-way set-associative cache controller that serves single-word loads (I-cache class). It owns the tag, valid and data storage and the lookup/refill state machine. It drives the hit/miss/fill event side of the replacement-policy interface and consumes the victim way the policy returns. It sits between the core fetch/load port and the memory-side line-refill bus.

Parameters:
SETS, 128, number of sets (power of 2)
LINE_WORDS, 4, 32-bit words per line (power of 2)
ADDR_W, 32, byte address width
DATA_W, 32, word width

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
req_valid_i  in  1  load request
req_ready_o  out  1  controller can accept a request
req_addr_i  in  ADDR_W  word-aligned byte address
resp_valid_o  out  1  one-cycle response pulse; no backpressure
resp_data_o  out  DATA_W  requested word
flush_i  in  1  invalidate all lines
mem_req_valid_o  out  1  line refill request
mem_req_ready_i  in  1  refill request accepted
mem_req_addr_o  out  ADDR_W  line-aligned refill address
mem_rvalid_i  in  1  refill beat valid, words in ascending order
mem_rdata_i  in  DATA_W  refill beat data
rp_set_index_o  out  $clog2(SETS)  set under lookup/fill
rp_way0_valid_o  out  1  valid bit of way 0 in that set
rp_way1_valid_o  out  1  valid bit of way 1 in that set
rp_hit_o  out  1  hit pulse
rp_miss_o  out  1  miss pulse
rp_fill_o  out  1  fill-complete pulse
rp_way_hit_o  out  1  way that hit
rp_way_filled_o  out  1  way that was filled
rp_victim_i  in  1  victim way from replacement policy (combinational, valid while rp_miss_o=1)

Behaviour:
- Address split: byte offset [1:0]; word offset next $clog2(LINE_WORDS) bits; index next $clog2(SETS) bits; tag is the remaining upper bits.
- Reset: state IDLE, all valid bits 0, every output 0, except req_ready_o=1 after reset release. Tag and data contents are don't-care. Reset during any state aborts the operation at once; no response is issued for it.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- IDLE:
  - req_ready_o = !flush_i.
  - flush_i=1: clear all valid bits in one cycle and stay in IDLE. flush_i is ignored outside IDLE.
  - req_valid_i && req_ready_o: latch the address, go to LOOKUP.
- LOOKUP: compare the tag against both ways of the set; hit = valid && tag match.
  - On hit: rp_hit_o=1 and rp_way_hit_o=matching way for this cycle. resp_valid_o and resp_data_o are registered and appear next cycle. Go to IDLE.
  - Hit latency: request accepted at T gives response at T+2; req_ready_o=1 again at T+2.
  - Both ways matching cannot occur, because a fill never duplicates a tag. If it did, way 0 takes priority.
  - On miss: rp_miss_o=1, sample rp_victim_i into victim_q, go to MISS_REQ.
  - rp_set_index_o and rp_way*_valid_o reflect the latched set during LOOKUP, REFILL and RESP; they are 0 otherwise.
- MISS_REQ: hold mem_req_valid_o=1 with mem_req_addr_o={tag,index,0} stable until mem_req_ready_i. Go to REFILL on the handshake cycle.
- REFILL:
  - A beat counter of width $clog2(LINE_WORDS), starting at 0, counts mem_rvalid_i beats; each beat writes data[victim_q][set][count].
  - Clear the victim's valid bit on the first beat.
  - On the last beat (count wraps from LINE_WORDS-1 to 0): write the tag, set valid, pulse rp_fill_o with rp_way_filled_o=victim_q, go to RESP.
  - Gaps between beats are allowed.
- RESP: resp_valid_o=1 for one cycle with the requested word from the filled line, then go to IDLE.
- rp_hit_o, rp_miss_o and rp_fill_o are mutually exclusive, single-cycle pulses.
- Exactly one response per accepted request; only one request outstanding.

Decomposition:
- Package cache_pkg holds: state enum cache_state_e; localparams OFFSET_W, INDEX_W, TAG_W derived from the parameters; helper functions get_index, get_tag, get_word.
- One natural sub-module, cache_line_store: tag, valid and data arrays for two ways. It provides a combinational read port, a beat write port, a tag write and a flush-clear.

Test Plan:
- After reset, load 0x1000: rp_miss_o pulses, mem_req_addr_o=0x1000. Beats 0xA0,0xA1,0xA2,0xA3 → rp_fill_o with rp_way_filled_o=0; resp_data_o=0xA0.
- Load 0x1008 after that: rp_hit_o=1, rp_way_hit_o=0, response at T+2 with data 0xA2, no mem_req_valid_o.
- Loads 0x1000, 0x1800 and 0x2000 (same index, SETS=128): the second fills way 1 (rp_way1_valid_o=0 at its miss). The third, with rp_victim_i=0, replaces way 0. A later 0x1800 hits way 1.
- mem_req_ready_i held low 5 cycles: mem_req_valid_o stays 1 and mem_req_addr_o stays stable; REFILL is entered only on the handshake. Two-cycle gaps between beats still fill correctly.
- flush_i in IDLE, then load 0x1000: req_ready_o=0 during flush; the load misses.
- rst_ni asserted on the second refill beat: all outputs 0 and no response is issued. After release, load 0x1000 misses.
